// File: rtl/imem.sv
// Instruction memory: packs a little-endian byte stream into words, then serves fetches.
// Optional: define IMEM_CHECKSUM_EN to keep a running XOR of written words on checksum.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   load_valid/ready      byte load handshake (ready only while loading)
//   load_byte, load_last  program byte and end-of-program marker
//   instr_addr            fetch word index (core pc_next)
//   instr_data            registered fetch word (NOP_WORD unless running and in range)
//   last_pc               word index of the last program word
//   prog_ready            program loaded, fetch valid
//   error                 sticky overflow flag
//   checksum              XOR of all written words (0 when the feature is off)
module imem #(
  parameter int          DEPTH_LOG2 = 8,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [7:0]  load_byte,
  input  logic        load_last,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_data,
  output logic [31:0] last_pc,
  output logic        prog_ready,
  output logic        error,
  output logic [31:0] checksum
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t                state;
  logic [DEPTH_LOG2:0]   wr_ptr;
  logic [1:0]            byte_cnt;
  logic [31:0]           asm_q;
  logic [31:0]           mem [DEPTH];

  logic                  xfer;
  logic                  full;
  logic                  wr_en;
  logic [31:0]           word_next;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  in_range;

  assign load_ready = (state == LOAD);
  assign xfer       = load_valid && load_ready;

  // wr_ptr never exceeds DEPTH, so its MSB alone marks "every word written".
  assign full   = wr_ptr[DEPTH_LOG2];
  assign wr_idx = wr_ptr[DEPTH_LOG2-1:0];

  // Upper bytes of asm_q are still zero, so a partial word comes out zero-padded.
  assign word_next =
    asm_q | ({24'd0, load_byte} << {byte_cnt, 3'b000});

  assign wr_en = xfer && !full &&
                 ((byte_cnt == 2'd3) || load_last);

  assign rd_idx   = instr_addr[DEPTH_LOG2-1:0];
  assign in_range = (instr_addr >> DEPTH_LOG2) == 32'd0;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= word_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      wr_ptr     <= '0;
      byte_cnt   <= 2'd0;
      asm_q      <= 32'd0;
      last_pc    <= 32'd0;
      prog_ready <= 1'b0;
      error      <= 1'b0;
      instr_data <= NOP_WORD;
    end else begin
      instr_data <= NOP_WORD;
      unique case (state)
        LOAD: begin
          if (xfer) begin
            if (full) begin
              state <= ERR;
              error <= 1'b1;
            end else if (load_last) begin
              state      <= RUN;
              prog_ready <= 1'b1;
              last_pc    <= {{(31-DEPTH_LOG2){1'b0}}, wr_ptr};
              byte_cnt   <= 2'd0;
              asm_q      <= 32'd0;
            end else if (byte_cnt == 2'd3) begin
              wr_ptr   <= wr_ptr + 1'b1;
              byte_cnt <= 2'd0;
              asm_q    <= 32'd0;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
              asm_q    <= word_next;
            end
          end
        end
        RUN: begin
          instr_data <= in_range ? mem[rd_idx] : NOP_WORD;
        end
        ERR: begin
          error <= 1'b1;
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

`ifdef IMEM_CHECKSUM_EN
  logic [31:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= 32'd0;
    end else if (wr_en) begin
      csum_q <= csum_q ^ word_next;
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_imem.sv
// Bench for imem: two instances (256 words and 4 words) share one stimulus stream.
// A byte-list model predicts every output; directed literals pin key values.
module tb_imem;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = 8'd0;
  logic        load_last = 1'b0;
  logic [31:0] instr_addr = 32'd0;

  logic        lr   [2];
  logic [31:0] idat [2];
  logic [31:0] lpc  [2];
  logic        prd  [2];
  logic        err  [2];
  logic [31:0] csum [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem #(.DEPTH_LOG2(8)) u_big (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(lr[0]),
    .load_byte(load_byte), .load_last(load_last),
    .instr_addr(instr_addr), .instr_data(idat[0]),
    .last_pc(lpc[0]), .prog_ready(prd[0]),
    .error(err[0]), .checksum(csum[0])
  );

  imem #(.DEPTH_LOG2(2)) u_small (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(lr[1]),
    .load_byte(load_byte), .load_last(load_last),
    .instr_addr(instr_addr), .instr_data(idat[1]),
    .last_pc(lpc[1]), .prog_ready(prd[1]),
    .error(err[1]), .checksum(csum[1])
  );

  // ---------------- model ----------------
  int          m_n    [2];
  logic        m_run  [2];
  logic        m_err  [2];
  logic [31:0] m_lpc  [2];
  logic [31:0] m_idat [2];
  logic        m_known[2];
  logic [7:0]  m_b    [2][1024];

  function automatic int words(input int k);
    return (k == 0) ? 256 : 4;
  endfunction

  function automatic logic [31:0] mword(input int k, input int i);
    logic [31:0] w;
    w = 32'd0;
    for (int j = 0; j < 4; j++) begin
      if (4*i + j < m_n[k]) w[8*j +: 8] = m_b[k][4*i + j];
    end
    return w;
  endfunction

  function automatic logic [31:0] exp_csum(input int k);
    logic [31:0] x;
    int cnt;
    x = 32'd0;
`ifdef IMEM_CHECKSUM_EN
    cnt = m_run[k] ? (m_n[k] + 3) / 4 : m_n[k] / 4;
    for (int i = 0; i < cnt; i++) x = x ^ mword(k, i);
`else
    cnt = 0;
`endif
    return x ^ 32'(cnt * 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_n[k] = 0;
        m_run[k] = 1'b0;
        m_err[k] = 1'b0;
        m_lpc[k] = 32'd0;
        m_idat[k] = NOP;
        m_known[k] = 1'b1;
      end else begin
        m_known[k] = 1'b1;
        m_idat[k] = NOP;
        if (m_run[k] && instr_addr < 32'(words(k))) begin
          m_known[k] = int'(instr_addr) < (m_n[k] + 3) / 4;
          m_idat[k] = mword(k, int'(instr_addr));
        end
        if (!m_run[k] && !m_err[k] && load_valid) begin
          if (m_n[k] >= 4 * words(k)) begin
            m_err[k] = 1'b1;
          end else begin
            m_b[k][m_n[k]] = load_byte;
            m_n[k]++;
            if (load_last) begin
              m_run[k] = 1'b1;
              m_lpc[k] = 32'((m_n[k] - 1) / 4);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int k,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h",
               nm, k, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("load_ready", k, 32'(lr[k]),
          32'(!m_run[k] && !m_err[k]));
      chk("prog_ready", k, 32'(prd[k]), 32'(m_run[k]));
      chk("error", k, 32'(err[k]), 32'(m_err[k]));
      chk("last_pc", k, lpc[k], m_lpc[k]);
      chk("checksum", k, csum[k], exp_csum(k));
      if (m_known[k]) chk("instr_data", k, idat[k], m_idat[k]);
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] t1 [8] = '{8'h13, 8'h00, 8'h00, 8'h00,
                         8'h93, 8'h00, 8'h10, 8'h00};

`ifdef IMEM_CHECKSUM_EN
  localparam logic [31:0] CS1 = 32'h0010_0080;
  localparam logic [31:0] CS2 = 32'h0000_00B8;
`else
  localparam logic [31:0] CS1 = 32'd0;
  localparam logic [31:0] CS2 = 32'd0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic l);
    load_valid = 1'b1;
    load_byte = b;
    load_last = l;
    tick();
    load_valid = 1'b0;
    load_last = 1'b0;
    load_byte = 8'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_load_ready", k, 32'(lr[k]), 32'd1);
      chk("rst_instr_data", k, idat[k], NOP);
      chk("rst_last_pc", k, lpc[k], 32'd0);
      chk("rst_prog_ready", k, 32'(prd[k]), 32'd0);
      chk("rst_error", k, 32'(err[k]), 32'd0);
      chk("rst_checksum", k, csum[k], 32'd0);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load_t1(input logic gaps);
    for (int i = 0; i < 8; i++) begin
      send(t1[i], i == 7);
      if (gaps && i < 7) begin
        load_byte = 8'($urandom);
        load_last = 1'($urandom);
        tick();
        load_last = 1'b0;
      end
    end
  endtask

  task automatic check_t1();
    for (int k = 0; k < 2; k++) begin
      chk("t1_prog_ready", k, 32'(prd[k]), 32'd1);
      chk("t1_last_pc", k, lpc[k], 32'd1);
      chk("t1_load_ready", k, 32'(lr[k]), 32'd0);
      chk("t1_checksum", k, csum[k], CS1);
    end
    instr_addr = 32'd1;
    tick();
    chk("t1_fetch1", 0, idat[0], 32'h0010_0093);
    chk("t1_fetch1", 1, idat[1], 32'h0010_0093);
    instr_addr = 32'd0;
    tick();
    chk("t1_fetch0", 0, idat[0], 32'h0000_0013);
  endtask

  initial begin
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // basic load and fetch, then out-of-range and ignored traffic
    do_reset();
    load_t1(1'b0);
    check_t1();
    instr_addr = 32'h100;
    tick();
    chk("oor_fetch", 0, idat[0], NOP);
    chk("oor_fetch", 1, idat[1], NOP);
    instr_addr = 32'd0;
    send(8'hFF, 1'b1);
    chk("run_ignores_load", 0, lpc[0], 32'd1);

    // partial last word
    do_reset();
    send(8'h13, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'hAB, 1'b1);
    chk("part_last_pc", 0, lpc[0], 32'd1);
    chk("part_checksum", 0, csum[0], CS2);
    instr_addr = 32'd1;
    tick();
    chk("part_fetch", 0, idat[0], 32'h0000_00AB);
    instr_addr = 32'd0;

    // gaps with junk between valid bytes
    do_reset();
    load_t1(1'b1);
    check_t1();

    // overflow on the 4-word instance
    do_reset();
    for (int i = 0; i < 17; i++) send(8'(i + 1), 1'b0);
    chk("ovf_error", 1, 32'(err[1]), 32'd1);
    chk("ovf_load_ready", 1, 32'(lr[1]), 32'd0);
    chk("ovf_prog_ready", 1, 32'(prd[1]), 32'd0);
    chk("ovf_big_ok", 0, 32'(err[0]), 32'd0);
    repeat (2) tick();
    chk("ovf_instr_data", 1, idat[1], NOP);

    // exactly full with last on the 16th byte
    do_reset();
    for (int i = 0; i < 16; i++) send(8'(i + 1), i == 15);
    chk("full_last_pc", 1, lpc[1], 32'd3);
    chk("full_error", 1, 32'(err[1]), 32'd0);
    chk("full_last_pc", 0, lpc[0], 32'd3);
    instr_addr = 32'd3;
    tick();
    chk("full_fetch3", 1, idat[1], 32'h100F_0E0D);
    instr_addr = 32'd0;

    // reset mid-load, then a clean reload
    do_reset();
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b0);
    do_reset();
    load_t1(1'b0);
    check_t1();

    // overflow on the 256-word instance
    do_reset();
    for (int i = 0; i < 1025; i++) send(8'($urandom), 1'b0);
    chk("big_ovf_error", 0, 32'(err[0]), 32'd1);
    chk("big_ovf_ready", 0, 32'(lr[0]), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
